// File: rtl/id_ex_operand_stage.sv
// rtl/id_ex_operand_stage.sv - register file, operand muxes and ID/EX pipeline register
// Feeds the ALU with registered opcode and operands; write-back is bypassed into same-cycle reads.
module id_ex_operand_stage #(
  parameter logic [31:0] STACK_INIT = 32'h0000_2FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        stall,
  input  logic        flush,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rd,
  input  logic        rd_write_in,
  input  logic [31:0] imm,
  input  logic [31:0] pc,
  input  logic [4:0]  alu_op_in,
  input  logic        alu_src_a_pc,
  input  logic        alu_src_b_imm,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        out_valid,
  output logic [4:0]  alu_op,
  output logic [31:0] alu_in_1,
  output logic [31:0] alu_in_2,
  output logic [31:0] rs2_data_out,
  output logic [4:0]  rd_out,
  output logic        rd_write_out,
  output logic [31:0] pc_out
);

  logic [31:0] rf_q [32];

  logic [31:0] rs1_data, rs2_data, op_a_d, op_b_d;

  logic        valid_q, rd_write_q;
  logic [4:0]  alu_op_q, rd_q;
  logic [31:0] op_a_q, op_b_q, rs2_data_q, pc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= (i == 2) ? STACK_INIT : 32'h0;
      end
    end else if (wb_en && (wb_rd != 5'd0)) begin
      rf_q[wb_rd] <= wb_data;
    end
  end

  // Bypass lets an instruction captured at the write-back edge see the new value.
  always_comb begin
    rs1_data = 32'h0;
    if (rs1 != 5'd0) begin
      rs1_data = (wb_en && (wb_rd == rs1)) ? wb_data : rf_q[rs1];
    end
    rs2_data = 32'h0;
    if (rs2 != 5'd0) begin
      rs2_data = (wb_en && (wb_rd == rs2)) ? wb_data : rf_q[rs2];
    end
    op_a_d = alu_src_a_pc  ? pc  : rs1_data;
    op_b_d = alu_src_b_imm ? imm : rs2_data;
  end

  always_ff @(posedge clk) begin
    if (reset || flush || (!stall && !in_valid)) begin
      valid_q    <= 1'b0;
      alu_op_q   <= 5'd0;
      op_a_q     <= 32'h0;
      op_b_q     <= 32'h0;
      rs2_data_q <= 32'h0;
      rd_q       <= 5'd0;
      rd_write_q <= 1'b0;
      pc_q       <= 32'h0;
    end else if (!stall) begin
      valid_q    <= 1'b1;
      alu_op_q   <= alu_op_in;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      rs2_data_q <= rs2_data;
      rd_q       <= rd;
      rd_write_q <= rd_write_in;
      pc_q       <= pc;
    end
  end

  assign out_valid    = valid_q;
  assign alu_op       = alu_op_q;
  assign alu_in_1     = op_a_q;
  assign alu_in_2     = op_b_q;
  assign rs2_data_out = rs2_data_q;
  assign rd_out       = rd_q;
  assign rd_write_out = rd_write_q;
  assign pc_out       = pc_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb/tb_id_ex_operand_stage.sv - directed scoreboard bench for id_ex_operand_stage
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        reset, in_valid, stall, flush;
  logic [4:0]  rs1, rs2, rd, alu_op_in, wb_rd;
  logic        rd_write_in, alu_src_a_pc, alu_src_b_imm, wb_en;
  logic [31:0] imm, pc, wb_data;
  logic        out_valid, rd_write_out;
  logic [4:0]  alu_op, rd_out;
  logic [31:0] alu_in_1, alu_in_2, rs2_data_out, pc_out;

  id_ex_operand_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
    .rs1(rs1), .rs2(rs2), .rd(rd), .rd_write_in(rd_write_in), .imm(imm), .pc(pc),
    .alu_op_in(alu_op_in), .alu_src_a_pc(alu_src_a_pc), .alu_src_b_imm(alu_src_b_imm),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .alu_op(alu_op), .alu_in_1(alu_in_1), .alu_in_2(alu_in_2),
    .rs2_data_out(rs2_data_out), .rd_out(rd_out), .rd_write_out(rd_write_out), .pc_out(pc_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] s;
    logic [4:0]  rd;
    logic        w;
    logic [31:0] pc;
  } exp_t;

  exp_t        sb[$];
  exp_t        last_e;
  logic [31:0] m_rf [32];
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'h0;
    if (wb_en && wb_rd == idx) return wb_data;
    return m_rf[idx];
  endfunction

  // One clock: predict from current inputs, push, clock, pop and compare.
  task automatic step(input string tag);
    exp_t e, got;
    logic [31:0] r1, r2;
    e  = '0;
    r1 = m_read(rs1);
    r2 = m_read(rs2);
    if (reset || flush) e = '0;
    else if (stall) e = last_e;
    else if (in_valid) begin
      e.v  = 1'b1;
      e.op = alu_op_in;
      e.a  = alu_src_a_pc ? pc : r1;
      e.b  = alu_src_b_imm ? imm : r2;
      e.s  = r2;
      e.rd = rd;
      e.w  = rd_write_in;
      e.pc = pc;
    end
    sb.push_back(e);
    last_e = e;
    if (reset) begin
      for (int i = 0; i < 32; i++) m_rf[i] = (i == 2) ? 32'h0000_2FFC : 32'h0;
    end else if (wb_en && wb_rd != 5'd0) m_rf[wb_rd] = wb_data;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'h1, 32'h0);
    end else begin
      got = sb.pop_front();
      chk({tag, "_valid"}, {31'h0, out_valid}, {31'h0, got.v});
      chk({tag, "_op"},    {27'h0, alu_op},    {27'h0, got.op});
      chk({tag, "_a"},     alu_in_1,           got.a);
      chk({tag, "_b"},     alu_in_2,           got.b);
      chk({tag, "_s"},     rs2_data_out,       got.s);
      chk({tag, "_rd"},    {27'h0, rd_out},    {27'h0, got.rd});
      chk({tag, "_w"},     {31'h0, rd_write_out}, {31'h0, got.w});
      chk({tag, "_pc"},    pc_out,             got.pc);
    end
  endtask

  task automatic idle_inputs();
    in_valid = 0; stall = 0; flush = 0; rs1 = 0; rs2 = 0; rd = 0; rd_write_in = 0;
    imm = 0; pc = 0; alu_op_in = 0; alu_src_a_pc = 0; alu_src_b_imm = 0;
    wb_en = 0; wb_rd = 0; wb_data = 0;
  endtask

  initial begin
    last_e = '0;
    for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
    idle_inputs();
    reset = 1;
    @(posedge clk); #1;
    step("rst1");
    step("rst2");
    chk("rst_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_a", alu_in_1, 32'h0);

    reset = 0; in_valid = 1; rs1 = 2;
    step("sp");
    chk("sp_const", alu_in_1, 32'h0000_2FFC);

    in_valid = 0; wb_en = 1; wb_rd = 5; wb_data = 32'h1234;
    step("wr5");
    wb_en = 0; in_valid = 1; rs1 = 5; rs2 = 0;
    step("rd5");
    chk("rd5_a_const", alu_in_1, 32'h1234);
    chk("rd5_b_const", alu_in_2, 32'h0);

    wb_en = 1; wb_rd = 7; wb_data = 32'hDEAD_BEEF; rs2 = 7;
    step("byp");
    chk("byp_b_const", alu_in_2, 32'hDEAD_BEEF);
    chk("byp_s_const", rs2_data_out, 32'hDEAD_BEEF);

    in_valid = 0; wb_rd = 0; wb_data = 32'hFFFF_FFFF;
    step("x0wr");
    wb_en = 0; in_valid = 1; rs1 = 0;
    step("x0rd");
    chk("x0rd_const", alu_in_1, 32'h0);
    wb_en = 1; wb_rd = 0; wb_data = 32'hFFFF_FFFF;
    step("x0byp");
    chk("x0byp_const", alu_in_1, 32'h0);
    wb_en = 0;

    pc = 32'h100; imm = 32'hFFFF_FFF8; alu_src_a_pc = 1; alu_src_b_imm = 1;
    alu_op_in = 5'd0; rs2 = 7;
    step("mux");
    chk("mux_a_const", alu_in_1, 32'h100);
    chk("mux_b_const", alu_in_2, 32'hFFFF_FFF8);
    chk("mux_s_const", rs2_data_out, 32'hDEAD_BEEF);

    alu_src_a_pc = 0; alu_src_b_imm = 0; rs1 = 5; rs2 = 2; rd = 3; rd_write_in = 1;
    alu_op_in = 5'h3; pc = 32'h200;
    step("ldA");
    stall = 1; rs1 = 9; rs2 = 10; rd = 11; pc = 32'h300; alu_op_in = 5'h1F;
    wb_en = 1; wb_rd = 5; wb_data = 32'h5555_5555;
    step("stl1");
    wb_en = 0;
    step("stl2");
    step("stl3");
    chk("stl_a_const", alu_in_1, 32'h1234);
    chk("stl_rd_const", {27'h0, rd_out}, 32'd3);
    flush = 1;
    step("stlfl");
    chk("stlfl_valid_const", {31'h0, out_valid}, 32'h0);
    chk("stlfl_w_const", {31'h0, rd_write_out}, 32'h0);
    flush = 0; stall = 0; rs1 = 5;
    step("post");
    chk("post_a_const", alu_in_1, 32'h5555_5555);

    stall = 1; reset = 1;
    step("rststl");
    reset = 0; stall = 0; rs1 = 5; rs2 = 2;
    step("afterrst");
    chk("afterrst_a_const", alu_in_1, 32'h0);
    chk("afterrst_s_const", rs2_data_out, 32'h0000_2FFC);

    for (int n = 0; n < 40; n++) begin
      in_valid = 1'($urandom); stall = ($urandom_range(0, 3) == 0); flush = ($urandom_range(0, 5) == 0);
      rs1 = 5'($urandom); rs2 = 5'($urandom); rd = 5'($urandom); rd_write_in = 1'($urandom);
      imm = $urandom; pc = $urandom; alu_op_in = 5'($urandom);
      alu_src_a_pc = 1'($urandom); alu_src_b_imm = 1'($urandom);
      wb_en = 1'($urandom); wb_rd = 5'($urandom); wb_data = $urandom;
      step("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
